// File: rtl/logic_arb.sv
// logic_arb: two-requester round-robin arbiter that sequences operations
// through one shared 32-bit bitwise logic unit (AND/OR/XOR/NOR).
// One operation is in flight at a time: accept -> execute -> respond.
module logic_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [1:0]       req_op_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [1:0]       req_op_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,

    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_data,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_last;
    logic             r_owner;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_grant_0;
    logic             w_grant_1;
    logic             w_accept;
    logic             w_rsp_done;
    logic [WIDTH-1:0] w_result;

    // Round-robin winner: a lone requester always wins; under contention the
    // requester that was not served last wins (r_last==1 favours requester 0).
    always_comb begin
        w_grant_0 = req_valid_0 && (!req_valid_1 || r_last);
        w_grant_1 = req_valid_1 && (!req_valid_0 || !r_last);
    end

    // State register; an asynchronous reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs, all defaulted before the state decode.
    always_comb begin
        w_next_state = r_state;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        rsp_valid_0  = 1'b0;
        rsp_valid_1  = 1'b0;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_0 = w_grant_0;
                req_ready_1 = w_grant_1;
                if (w_grant_0 || w_grant_1) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid_0 = !r_owner;
                rsp_valid_1 = r_owner;
                w_rsp_done  = r_owner ? rsp_ready_1 : rsp_ready_0;
                if (w_rsp_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shared bitwise logic unit; every bit is independent, no carries.
    always_comb begin
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NOR:  w_result = ~(r_a | r_b);
            default: w_result = '0;
        endcase
    end

    // Operand capture on acceptance and result capture during execute; the
    // last-served pointer moves only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_1;
                r_last  <= w_grant_1;
                r_op    <= w_grant_1 ? req_op_1 : req_op_0;
                r_a     <= w_grant_1 ? req_a_1  : req_a_0;
                r_b     <= w_grant_1 ? req_b_1  : req_b_0;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= w_result;
            end
        end
    end

    // Result is held in a register so it stays stable under backpressure.
    always_comb begin
        rsp_data = r_rsp_data;
        busy     = (r_state != IDLE);
    end

endmodule

// File: tb/tb_logic_arb.sv
// tb_logic_arb: self-checking bench for logic_arb. Inputs change 1ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_logic_arb;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_0, req_valid_1;
    logic             req_ready_0, req_ready_1;
    logic [1:0]       req_op_0, req_op_1;
    logic [WIDTH-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic             rsp_valid_0, rsp_valid_1;
    logic             rsp_ready_0, rsp_ready_1;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int nChecks = 0;
    int nFails  = 0;
    int modelLast;

    logic_arb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .busy(busy)
    );

    // Free-running 10ns clock
    always #5 clk = ~clk;

    // Reference semantics of the logic unit, straight from the opcode table
    function automatic logic [WIDTH-1:0] refLogic(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        req_valid_0 = 0; req_valid_1 = 0;
        req_op_0 = 0; req_op_1 = 0;
        req_a_0 = 0; req_b_0 = 0; req_a_1 = 0; req_b_1 = 0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
    endtask

    // Reset values and combinational ready during reset
    task automatic test_reset;
        rst_n = 0;
        idleInputs();
        #12;
        nChecks++;
        if ({busy, rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0} !== 5'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000",
                     {busy, rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0});
        end
        nChecks++;
        if (rsp_data !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL reset_data got=%h want=00000000", rsp_data);
        end
        req_valid_1 = 1;
        #1;
        nChecks++;
        if ({req_ready_1, req_ready_0} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL reset_comb_ready got=%b want=10", {req_ready_1, req_ready_0});
        end
        req_valid_1 = 0;
        @(negedge clk);
        rst_n = 1;
        modelLast = 1;
        tick();
    endtask

    // Lone requester 0 AND operation with 2-cycle response latency
    task automatic test_single;
        req_valid_0 = 1; req_op_0 = 2'b00;
        req_a_0 = 32'hF0F0_F0F0; req_b_0 = 32'hFF00_FF00; rsp_ready_0 = 1;
        @(negedge clk);
        nChecks++;
        if ({req_ready_1, req_ready_0} !== 2'b01) begin
            nFails++;
            $display("[TB] FAIL single_grant got=%b want=01", {req_ready_1, req_ready_0});
        end
        tick();
        req_valid_0 = 0; req_a_0 = $urandom; req_b_0 = $urandom; req_op_0 = 2'($urandom);
        @(negedge clk);
        nChecks++;
        if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL single_exec got=%b want=100", {busy, rsp_valid_1, rsp_valid_0});
        end
        tick();
        @(negedge clk);
        nChecks++;
        if ({rsp_valid_1, rsp_valid_0} !== 2'b01 || rsp_data !== 32'hF000_F000) begin
            nFails++;
            $display("[TB] FAIL single_resp got=%b/%h want=01/f000f000",
                     {rsp_valid_1, rsp_valid_0}, rsp_data);
        end
        tick();
        rsp_ready_0 = 0;
        @(negedge clk);
        nChecks++;
        if ({busy, rsp_valid_0} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL single_done got=%b want=00", {busy, rsp_valid_0});
        end
        modelLast = 0;
        tick();
    endtask

    // OR, XOR, NOR through requester 1 against the documented results
    task automatic test_opcodes;
        logic [WIDTH-1:0] want [3];
        want[0] = 32'hAFAF_5F5F;
        want[1] = 32'hA5A5_5A5A;
        want[2] = 32'h5050_A0A0;
        for (int k = 0; k < 3; k++) begin
            req_valid_1 = 1; req_op_1 = 2'(k + 1);
            req_a_1 = 32'hAAAA_5555; req_b_1 = 32'h0F0F_0F0F; rsp_ready_1 = 1;
            tick();
            req_valid_1 = 0;
            tick();
            @(negedge clk);
            nChecks++;
            if ({rsp_valid_1, rsp_valid_0} !== 2'b10 || rsp_data !== want[k]) begin
                nFails++;
                $display("[TB] FAIL opcode_%0d got=%b/%h want=10/%h", k + 1,
                         {rsp_valid_1, rsp_valid_0}, rsp_data, want[k]);
            end
            tick();
            rsp_ready_1 = 0;
        end
        modelLast = 1;
    endtask

    // Both requesters valid continuously: alternating grants, 3 cycles each
    task automatic test_round_robin;
        int   winner;
        int   prevWinner;
        time  grantTime;
        time  prevGrant;
        logic [WIDTH-1:0] expData;
        req_valid_0 = 1; req_op_0 = 2'b10; req_a_0 = 32'h1234_5678; req_b_0 = 32'hFFFF_0000;
        req_valid_1 = 1; req_op_1 = 2'b00; req_a_1 = 32'hDEAD_BEEF; req_b_1 = 32'h0FF0_0FF0;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        prevGrant  = 0;
        prevWinner = modelLast;
        for (int n = 0; n < 4; n++) begin
            winner  = 1 - modelLast;
            expData = (winner == 0) ? refLogic(req_op_0, req_a_0, req_b_0)
                                    : refLogic(req_op_1, req_a_1, req_b_1);
            @(negedge clk);
            grantTime = $time;
            nChecks++;
            if ({req_ready_1, req_ready_0} !== ((winner == 0) ? 2'b01 : 2'b10) || winner == prevWinner) begin
                nFails++;
                $display("[TB] FAIL rr_grant_%0d got=%b want_winner=%0d", n,
                         {req_ready_1, req_ready_0}, winner);
            end
            if (n > 0) begin
                nChecks++;
                if (grantTime - prevGrant !== 30) begin
                    nFails++;
                    $display("[TB] FAIL rr_period_%0d got=%0t want=30", n, grantTime - prevGrant);
                end
            end
            prevGrant  = grantTime;
            prevWinner = winner;
            modelLast  = winner;
            tick();
            @(negedge clk);
            nChecks++;
            if ({req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0} !== 4'b0) begin
                nFails++;
                $display("[TB] FAIL rr_exec_%0d got=%b want=0000", n,
                         {req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0});
            end
            tick();
            @(negedge clk);
            nChecks++;
            if ({rsp_valid_1, rsp_valid_0} !== ((winner == 0) ? 2'b01 : 2'b10) || rsp_data !== expData) begin
                nFails++;
                $display("[TB] FAIL rr_resp_%0d got=%b/%h want_owner=%0d/%h", n,
                         {rsp_valid_1, rsp_valid_0}, rsp_data, winner, expData);
            end
            tick();
        end
        idleInputs();
    endtask

    // Response held for 10 cycles with a competing request pending
    task automatic test_backpressure;
        logic [WIDTH-1:0] expData;
        req_valid_1 = 1; req_op_1 = 2'b01; req_a_1 = 32'h0000_FFFF; req_b_1 = 32'h00F0_0F00;
        expData = refLogic(2'b01, 32'h0000_FFFF, 32'h00F0_0F00);
        tick();
        req_valid_1 = 0;
        tick();
        req_valid_0 = 1; req_op_0 = 2'b11; req_a_0 = $urandom; req_b_0 = $urandom;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nChecks++;
            if ({busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0} !== 5'b10010 ||
                rsp_data !== expData) begin
                nFails++;
                $display("[TB] FAIL bp_hold_%0d got=%b/%h want=10010/%h", k,
                         {busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0}, rsp_data, expData);
            end
            tick();
        end
        rsp_ready_1 = 1;
        tick();
        req_valid_0 = 0; rsp_ready_1 = 0;
        @(negedge clk);
        nChecks++;
        if ({busy, rsp_valid_1} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL bp_release got=%b want=00", {busy, rsp_valid_1});
        end
        modelLast = 1;
        tick();
    endtask

    // Non-owner ready must not complete requester 0's response
    task automatic test_cross_ready;
        req_valid_0 = 1; req_op_0 = 2'b11; req_a_0 = 32'h8000_0001; req_b_0 = 32'h0000_0010;
        tick();
        req_valid_0 = 0;
        tick();
        rsp_ready_1 = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nChecks++;
            if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b101 || rsp_data !== 32'h7FFF_FFEE) begin
                nFails++;
                $display("[TB] FAIL cross_ready_%0d got=%b/%h want=101/7fffffee", k,
                         {busy, rsp_valid_1, rsp_valid_0}, rsp_data);
            end
            tick();
        end
        rsp_ready_1 = 0; rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL cross_done got=%b want=0", busy);
        end
        modelLast = 0;
        tick();
    endtask

    // Reset during EXEC: async clear, no response, pointer back to 1
    task automatic test_reset_midop;
        req_valid_0 = 1; req_op_0 = 2'b01; req_a_0 = 32'h1111_0000; req_b_0 = 32'h0000_2222;
        rsp_ready_0 = 1;
        tick();
        req_valid_0 = 0;
        #2;
        rst_n = 0;
        #1;
        nChecks++;
        if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL midop_async got=%b want=000", {busy, rsp_valid_1, rsp_valid_0});
        end
        @(negedge clk);
        rst_n = 1;
        modelLast = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nChecks++;
            if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000) begin
                nFails++;
                $display("[TB] FAIL midop_norsp_%0d got=%b want=000", k, {busy, rsp_valid_1, rsp_valid_0});
            end
        end
        tick();
        req_valid_0 = 1; req_valid_1 = 1;
        req_op_1 = 2'b10; req_a_1 = $urandom; req_b_1 = $urandom;
        @(negedge clk);
        nChecks++;
        if ({req_ready_1, req_ready_0} !== 2'b01) begin
            nFails++;
            $display("[TB] FAIL midop_first_grant got=%b want=01", {req_ready_1, req_ready_0});
        end
        tick();
        idleInputs();
        rsp_ready_0 = 1;
        tick();
        @(negedge clk);
        nChecks++;
        if ({rsp_valid_1, rsp_valid_0} !== 2'b01 || rsp_data !== 32'h1111_2222) begin
            nFails++;
            $display("[TB] FAIL midop_resp got=%b/%h want=01/11112222", {rsp_valid_1, rsp_valid_0}, rsp_data);
        end
        tick();
        rsp_ready_0 = 0;
        modelLast = 0;
    endtask

    // Random traffic: requesters raise and hold requests, random backpressure
    task automatic test_random;
        logic             p0, p1;
        logic [1:0]       o0, o1;
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic [WIDTH-1:0] expData;
        int               winner;
        int               delay;
        p0 = 0; p1 = 0;
        o0 = 0; o1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        for (int t = 0; t < 40; t++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1; o0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1; o1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
            end
            if (!p0 && !p1) begin
                p1 = 1; o1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
            end
            req_valid_0 = p0; req_op_0 = o0; req_a_0 = a0; req_b_0 = b0;
            req_valid_1 = p1; req_op_1 = o1; req_a_1 = a1; req_b_1 = b1;
            rsp_ready_0 = 1'($urandom); rsp_ready_1 = 1'($urandom);
            if (p0 && p1) winner = 1 - modelLast;
            else          winner = p0 ? 0 : 1;
            expData = (winner == 0) ? refLogic(o0, a0, b0) : refLogic(o1, a1, b1);
            @(negedge clk);
            nChecks++;
            if ({busy, req_ready_1, req_ready_0} !== ((winner == 0) ? 3'b001 : 3'b010)) begin
                nFails++;
                $display("[TB] FAIL rand_grant_%0d got=%b want_winner=%0d", t,
                         {busy, req_ready_1, req_ready_0}, winner);
            end
            tick();
            modelLast = winner;
            if (winner == 0) begin
                p0 = 0; req_valid_0 = 0; req_a_0 = $urandom; req_b_0 = $urandom; req_op_0 = 2'($urandom);
            end else begin
                p1 = 0; req_valid_1 = 0; req_a_1 = $urandom; req_b_1 = $urandom; req_op_1 = 2'($urandom);
            end
            @(negedge clk);
            nChecks++;
            if ({busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0} !== 5'b10000) begin
                nFails++;
                $display("[TB] FAIL rand_exec_%0d got=%b want=10000", t,
                         {busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0});
            end
            tick();
            delay = $urandom_range(0, 3);
            for (int k = 0; k <= delay; k++) begin
                if (winner == 0) begin
                    rsp_ready_0 = (k == delay); rsp_ready_1 = 1'($urandom);
                end else begin
                    rsp_ready_1 = (k == delay); rsp_ready_0 = 1'($urandom);
                end
                @(negedge clk);
                nChecks++;
                if ({busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0} !==
                    ((winner == 0) ? 5'b10001 : 5'b10010) || rsp_data !== expData) begin
                    nFails++;
                    $display("[TB] FAIL rand_resp_%0d_%0d got=%b/%h want_owner=%0d/%h", t, k,
                             {busy, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0},
                             rsp_data, winner, expData);
                end
                tick();
            end
        end
        idleInputs();
        tick();
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_round_robin();
        test_backpressure();
        test_cross_ready();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
